pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 6: number of pipeline stages; stage 0 is PC, ascending toward writeback.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 1: cycles that flush stays asserted per accepted flush request; legal range 1..15.
REQ-003 SHALL have parameter WDT_LIMIT, default 255: consecutive-stall cycle count that trips the watchdog; legal range 1..65535.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port: clk  input  1  rising-edge clock.
REQ-006 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-007 SHALL have port: stallreq  input  NUM_STAGES  per-stage stall request; bit i set means stage i cannot advance.
REQ-008 SHALL have port: flush_req  input  1  single-cycle exception/flush request.
REQ-009 SHALL have port: flush_pc  input  32  restart address, valid with flush_req.
REQ-010 SHALL have port: stall  output  NUM_STAGES  per-stage hold; bit k set means stage k holds its contents.
REQ-011 SHALL have port: flush  output  1  clear all pipeline registers (registered).
REQ-012 SHALL have port: new_pc  output  32  restart address presented while flush=1 (registered).
REQ-013 SHALL have port: stall_cnt  output  16  consecutive stalled cycles, saturating at 16'hFFFF.

Function
REQ-014 SHALL drive stall combinationally with zero latency: for h = the highest set index of stallreq, stall[k]=1 for all k<=h and 0 for k>h; stall=0 when stallreq=0.
REQ-015 SHALL implement a state machine with states IDLE, STALL, FLUSH.
REQ-016 IDLE->STALL when stallreq!=0 and flush_req=0; STALL->IDLE when stallreq=0 and flush_req=0.
REQ-017 From any state, flush_req=1 SHALL enter FLUSH on the next edge, latch flush_pc into new_pc and load the flush counter with FLUSH_CYCLES.
REQ-018 In FLUSH, flush SHALL be 1 and stall SHALL be forced to 0 regardless of stallreq; the counter decrements each cycle; on reaching 0 the FSM goes to STALL if stallreq!=0, else IDLE.
REQ-019 flush_req during FLUSH SHALL restart the flush: counter reloaded, new_pc overwritten (latest request wins).
REQ-020 flush SHALL be 1 for exactly FLUSH_CYCLES consecutive cycles after the last flush_req; new_pc SHALL hold its value until the next flush_req.
REQ-021 stall_cnt SHALL increment each cycle stall!=0, saturate at 16'hFFFF, and clear to 0 on the first cycle stall=0 or when FLUSH is entered.
REQ-022 Simultaneous stallreq and flush_req SHALL give flush priority: stall=0 in the cycle flush_req is sampled, and the FLUSH state follows.

Reset
REQ-023 rst=1 SHALL immediately, without clock, force state IDLE, flush=0, new_pc=32'h0, stall_cnt=0, flush counter=0, and stall=0 regardless of stallreq.
REQ-024 Reset asserted mid-flush or mid-stall SHALL abort that operation; the first edge after release starts from IDLE.

Configuration
REQ-025 SHALL support macro STALL_WDT_EN: when defined, adds output stall_timeout (1 bit, registered), which is set to 1 when stall_cnt reaches WDT_LIMIT and held until rst or FLUSH entry.
REQ-026 With STALL_WDT_EN defined, stall_timeout=1 SHALL NOT alter stall; it is a status flag only.
REQ-027 Without STALL_WDT_EN, port stall_timeout and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 NUM_STAGES=6, stallreq=6'b000100 -> stall=6'b000111 in the same cycle; stallreq=6'b001100 -> stall=6'b001111.
REQ-029 stallreq=6'b001000 held 5 cycles -> stall_cnt reads 1,2,3,4,5; stallreq=0 -> stall_cnt=0 next cycle.
REQ-030 FLUSH_CYCLES=2, flush_req pulse with flush_pc=32'h0000_0040 while stallreq=6'b000100 -> stall=0 that cycle; flush=1 for 2 cycles with new_pc=32'h40; then STALL with stall=6'b000111.
REQ-031 Second flush_req with flush_pc=32'h80 during flush -> new_pc=32'h80, flush extended FLUSH_CYCLES from that request.
REQ-032 rst asserted mid-flush -> flush=0, new_pc=0 immediately, no clock edge required.
REQ-033 STALL_WDT_EN defined, WDT_LIMIT=4, stallreq held 6 cycles -> stall_timeout=1 once stall_cnt=4, stays 1 until flush_req.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard/flush controller.
// Generates per-stage stall holds from stall requests, sequences multi-cycle
// flushes with a restart PC, and counts consecutive stalled cycles.
// Optional feature macro: STALL_WDT_EN adds the stall_timeout watchdog flag.
module pipe_ctrl #(
  parameter int unsigned NUM_STAGES   = 6,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned WDT_LIMIT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stallreq,
  input  logic                  flush_req,
  input  logic [31:0]           flush_pc,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic [31:0]           new_pc,
  output logic [15:0]           stall_cnt
`ifdef STALL_WDT_EN
  ,
  output logic                  stall_timeout
`endif
);

  // Elaboration-time parameter range checks.
  if (NUM_STAGES < 1) begin : g_bad_stages
    $error("pipe_ctrl: NUM_STAGES must be at least 1");
  end
  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush
    $error("pipe_ctrl: FLUSH_CYCLES must be in 1..15");
  end
  if (WDT_LIMIT < 1 || WDT_LIMIT > 65535) begin : g_bad_wdt
    $error("pipe_ctrl: WDT_LIMIT must be in 1..65535");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_flush_cnt;
  logic                    r_flush;
  logic [31:0]             r_new_pc;
  logic [15:0]             r_stall_cnt;
  logic [15:0]             w_stall_cnt_nxt;
  logic [NUM_STAGES-1:0]   w_stall;
  logic                    w_req_any;
  logic                    w_acc;

  assign w_req_any = |stallreq;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a flush request overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_req) begin
      w_state_nxt = FLUSH;
    end else begin
      case (r_state)
        IDLE:    if (w_req_any) w_state_nxt = STALL;
        STALL:   if (!w_req_any) w_state_nxt = IDLE;
        FLUSH:   if (r_flush_cnt <= 4'd1) w_state_nxt = w_req_any ? STALL : IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Stall outputs: thermometer up from the highest requesting stage,
  // suppressed during reset, flush, and the cycle a flush is requested.
  always_comb begin
    w_stall = '0;
    w_acc   = 1'b0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      w_acc = w_acc | stallreq[NUM_STAGES-1-i];
      w_stall[NUM_STAGES-1-i] = w_acc;
    end
    if (rst || flush_req || (r_state == FLUSH)) begin
      w_stall = '0;
    end
  end

  // Flush length counter; loaded on each request so the latest one wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= '0;
    end else if (flush_req) begin
      r_flush_cnt <= 4'(FLUSH_CYCLES);
    end else if ((r_state == FLUSH) && (r_flush_cnt != 4'd0)) begin
      r_flush_cnt <= r_flush_cnt - 4'd1;
    end
  end

  // Registered flush strobe tracks the upcoming FLUSH state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush <= 1'b0;
    end else begin
      r_flush <= (w_state_nxt == FLUSH);
    end
  end

  // Restart address captured on each flush request and held until the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_new_pc <= '0;
    end else if (flush_req) begin
      r_new_pc <= flush_pc;
    end
  end

  // Saturating consecutive-stall count; any unstalled cycle clears it.
  always_comb begin
    w_stall_cnt_nxt = '0;
    if (w_stall != '0) begin
      w_stall_cnt_nxt = (r_stall_cnt == 16'hFFFF) ? r_stall_cnt : r_stall_cnt + 16'd1;
    end
  end

  // Stall counter register; flush entry clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (flush_req) begin
      r_stall_cnt <= '0;
    end else begin
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

`ifdef STALL_WDT_EN
  logic r_stall_timeout;

  // Sticky watchdog flag, raised alongside the count reaching the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_timeout <= 1'b0;
    end else if (flush_req) begin
      r_stall_timeout <= 1'b0;
    end else if (w_stall_cnt_nxt >= 16'(WDT_LIMIT)) begin
      r_stall_timeout <= 1'b1;
    end
  end

  assign stall_timeout = r_stall_timeout;
`endif

  assign stall     = w_stall;
  assign flush     = r_flush;
  assign new_pc    = r_new_pc;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed test of pipe_ctrl against a cycle-level model.
module tb_pipe_ctrl;
  localparam int NS  = 6;
  localparam int FC  = 2;
  localparam int WDT = 4;

  logic          clk;
  logic          rst;
  logic [NS-1:0] stallreq;
  logic          flush_req;
  logic [31:0]   flush_pc;
  logic [NS-1:0] stall;
  logic          flush;
  logic [31:0]   new_pc;
  logic [15:0]   stall_cnt;
`ifdef STALL_WDT_EN
  logic          stall_timeout;
`endif

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(.NUM_STAGES(NS), .FLUSH_CYCLES(FC), .WDT_LIMIT(WDT)) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .flush_req(flush_req),
    .flush_pc(flush_pc), .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cnt(stall_cnt)
`ifdef STALL_WDT_EN
    , .stall_timeout(stall_timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: remaining flush cycles, restart PC, stall run length, watchdog.
  int          m_rem;
  logic [31:0] m_pc;
  int          m_cnt;
  bit          m_to;
  logic [NS-1:0] m_s;

  function automatic logic [NS-1:0] exp_stall(input logic [NS-1:0] req, input logic fr,
                                              input int rem, input logic r);
    int h;
    h = -1;
    if (r || fr || rem > 0) return '0;
    for (int i = 0; i < NS; i++) if (req[i]) h = i;
    return NS'((1 << (h + 1)) - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rem = 0; m_pc = 32'h0; m_cnt = 0; m_to = 1'b0;
    end else begin
      m_s = exp_stall(stallreq, flush_req, m_rem, 1'b0);
      if (flush_req) begin
        m_rem = FC; m_pc = flush_pc; m_cnt = 0; m_to = 1'b0;
      end else begin
        if (m_rem > 0) m_rem--;
        if (m_s != '0) m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
        else m_cnt = 0;
        if (m_cnt >= WDT) m_to = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_stall", 32'(stall), 32'(exp_stall(stallreq, flush_req, m_rem, rst)));
    chk("m_flush", 32'(flush), 32'(m_rem > 0));
    chk("m_new_pc", new_pc, m_pc);
    chk("m_stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`ifdef STALL_WDT_EN
    chk("m_timeout", 32'(stall_timeout), 32'(m_to));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stallreq = 6'b111111; flush_req = 1'b0; flush_pc = 32'h0;
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_new_pc", new_pc, 32'h0);
    chk("rst_cnt", 32'(stall_cnt), 32'h0);
    tick();
    stallreq = '0;
    tick();
    rst = 1'b0;
    tick();

    // Thermometer stall, same cycle.
    stallreq = 6'b000100; #1 chk("therm_000100", 32'(stall), 32'h07);
    stallreq = 6'b001100; #1 chk("therm_001100", 32'(stall), 32'h0F);
    stallreq = 6'b100000; #1 chk("therm_100000", 32'(stall), 32'h3F);
    stallreq = 6'b000001; #1 chk("therm_000001", 32'(stall), 32'h01);
    tick();
    stallreq = '0;
    tick();

    // Stall count run of five, then clear.
    stallreq = 6'b001000;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("cnt_run", 32'(stall_cnt), 32'(i));
    end
    stallreq = '0;
    tick();
    chk("cnt_clear", 32'(stall_cnt), 32'h0);

    // Flush while stalled: flush wins, two flush cycles, then stall resumes.
    stallreq = 6'b000100; flush_req = 1'b1; flush_pc = 32'h40;
    #1 chk("flush_prio_stall", 32'(stall), 32'h0);
    tick();
    flush_req = 1'b0;
    chk("flush_c1", 32'(flush), 32'h1);
    chk("flush_pc40", new_pc, 32'h40);
    chk("flush_c1_stall", 32'(stall), 32'h0);
    tick();
    chk("flush_c2", 32'(flush), 32'h1);
    tick();
    chk("flush_end", 32'(flush), 32'h0);
    chk("post_flush_stall", 32'(stall), 32'h07);
    chk("post_flush_pc", new_pc, 32'h40);

    // Re-flush during flush: latest address wins and flush is extended.
    stallreq = '0; flush_req = 1'b1; flush_pc = 32'h100;
    tick();
    flush_req = 1'b0;
    chk("reflush_pc100", new_pc, 32'h100);
    tick();
    flush_req = 1'b1; flush_pc = 32'h80;
    tick();
    flush_req = 1'b0;
    chk("reflush_pc80", new_pc, 32'h80);
    chk("reflush_ext1", 32'(flush), 32'h1);
    tick();
    chk("reflush_ext2", 32'(flush), 32'h1);
    tick();
    chk("reflush_end", 32'(flush), 32'h0);
    chk("reflush_hold_pc", new_pc, 32'h80);

    // Long stall: watchdog trips at the limit and is held until flush.
    stallreq = 6'b000010;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("wdt_cnt", 32'(stall_cnt), 32'(i));
`ifdef STALL_WDT_EN
      chk("wdt_flag", 32'(stall_timeout), 32'(i >= WDT));
`endif
    end
    stallreq = '0;
    tick();
`ifdef STALL_WDT_EN
    chk("wdt_held", 32'(stall_timeout), 32'h1);
`endif
    flush_req = 1'b1; flush_pc = 32'h200;
    tick();
    flush_req = 1'b0;
`ifdef STALL_WDT_EN
    chk("wdt_clr", 32'(stall_timeout), 32'h0);
`endif
    tick();
    tick();

    // Asynchronous reset mid-flush, then restart from IDLE.
    flush_req = 1'b1; flush_pc = 32'hABC;
    tick();
    flush_req = 1'b0;
    chk("pre_rst_flush", 32'(flush), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("async_flush", 32'(flush), 32'h0);
    chk("async_pc", new_pc, 32'h0);
    stallreq = 6'b001000;
    #1 chk("rst_force_stall", 32'(stall), 32'h0);
    tick();
    rst = 1'b0;
    #1 chk("rel_stall", 32'(stall), 32'h0F);
    tick();
    chk("rel_cnt", 32'(stall_cnt), 32'h1);
    chk("rel_flush", 32'(flush), 32'h0);
    stallreq = '0;
    tick();
    tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
